instr_execute: RTL and testbench

//  EX stage of the 5-stage MIPS pipeline; consumes the ID/EX register outputs of the decode stage.

---
 rtl/mips_pkg.sv | 10 +
 rtl/alu.sv | 28 ++
 rtl/d_ff.sv | 16 +
 rtl/instr_execute.sv | 113 +++++++++++
 tb/tb_instr_execute.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: ALU operation encodings used by decode and execute.
package mips_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/alu.sv
// Combinational ALU: add/sub wrap without overflow, slt is signed, unknown ops yield 0.
module alu
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alu_ctrl,
  output logic [WIDTH-1:0] y,
  output logic             zero
);

  always_comb begin
    y = '0;
    unique case (alu_ctrl)
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_SLT: y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: y = '0;
    endcase
  end

  assign zero = (y == '0);

endmodule

// File: rtl/d_ff.sv
// Pipeline register with synchronous active-high clear.
module d_ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) q <= '0;
    else       q <= d;
  end

endmodule

// File: rtl/instr_execute.sv
// EX stage: ALU, beq/j resolution with PC redirect, wrong-path squash and EX/MEM register.
module instr_execute
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned SQUASH_SLOTS = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_ex_jump,
  input  logic             id_ex_branch,
  input  logic             id_ex_mem_to_reg_wr,
  input  logic             id_ex_mem_wr_en,
  input  logic             id_ex_alu_src_sel,
  input  logic             id_ex_reg_wr_en,
  input  logic [2:0]       id_ex_alu_ctrl,
  input  logic [4:0]       id_ex_reg_wr_addr,
  input  logic [WIDTH-1:0] id_ex_reg_rd_data1,
  input  logic [WIDTH-1:0] id_ex_reg_rd_data2,
  input  logic [WIDTH-1:0] id_ex_sign_imm_ext,
  input  logic [WIDTH-1:0] id_ex_pc_branch,
  input  logic [WIDTH-1:0] id_ex_pc_jump,
  output logic             pc_redirect,
  output logic [WIDTH-1:0] pc_target,
  output logic             flush_if_id,
  output logic             ex_mem_mem_to_reg_wr,
  output logic             ex_mem_mem_wr_en,
  output logic             ex_mem_reg_wr_en,
  output logic [4:0]       ex_mem_reg_wr_addr,
  output logic [WIDTH-1:0] ex_mem_alu_result,
  output logic [WIDTH-1:0] ex_mem_wr_data,
  output logic             ex_mem_valid
);

  localparam int unsigned CNT_W = $clog2(SQUASH_SLOTS + 1);

  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_y;
  logic             alu_zero;
  logic [CNT_W-1:0] squash_cnt;
  logic             live;
  logic             taken;

  logic             d_mem_to_reg_wr;
  logic             d_mem_wr_en;
  logic             d_reg_wr_en;
  logic [4:0]       d_reg_wr_addr;
  logic [WIDTH-1:0] d_alu_result;
  logic [WIDTH-1:0] d_wr_data;

  assign alu_b = id_ex_alu_src_sel ? id_ex_sign_imm_ext : id_ex_reg_rd_data2;

  alu #(.WIDTH(WIDTH)) u_alu (
    .a        (id_ex_reg_rd_data1),
    .b        (alu_b),
    .alu_ctrl (id_ex_alu_ctrl),
    .y        (alu_y),
    .zero     (alu_zero)
  );

  assign live        = (squash_cnt == '0);
  assign taken       = live & ((id_ex_branch & alu_zero) | id_ex_jump);
  assign pc_redirect = taken & ~reset;
  assign pc_target   = id_ex_jump ? id_ex_pc_jump : id_ex_pc_branch;
  assign flush_if_id = pc_redirect;

  // taken implies live, so the load and decrement branches never compete
  always_ff @(posedge clk) begin
    if (reset)                  squash_cnt <= '0;
    else if (taken)             squash_cnt <= CNT_W'(SQUASH_SLOTS);
    else if (squash_cnt != '0)  squash_cnt <= squash_cnt - CNT_W'(1);
  end

  always_comb begin
    d_mem_to_reg_wr = 1'b0;
    d_mem_wr_en     = 1'b0;
    d_reg_wr_en     = 1'b0;
    d_reg_wr_addr   = '0;
    d_alu_result    = '0;
    d_wr_data       = '0;
    if (live) begin
      d_mem_to_reg_wr = id_ex_mem_to_reg_wr;
      d_mem_wr_en     = id_ex_mem_wr_en;
      d_reg_wr_en     = id_ex_reg_wr_en;
      d_reg_wr_addr   = id_ex_reg_wr_addr;
      d_alu_result    = alu_y;
      d_wr_data       = id_ex_reg_rd_data2;
    end
  end

  d_ff #(.WIDTH(1)) u_ff_m2r (
    .clk(clk), .reset(reset), .d(d_mem_to_reg_wr), .q(ex_mem_mem_to_reg_wr)
  );
  d_ff #(.WIDTH(1)) u_ff_mwe (
    .clk(clk), .reset(reset), .d(d_mem_wr_en), .q(ex_mem_mem_wr_en)
  );
  d_ff #(.WIDTH(1)) u_ff_rwe (
    .clk(clk), .reset(reset), .d(d_reg_wr_en), .q(ex_mem_reg_wr_en)
  );
  d_ff #(.WIDTH(5)) u_ff_addr (
    .clk(clk), .reset(reset), .d(d_reg_wr_addr), .q(ex_mem_reg_wr_addr)
  );
  d_ff #(.WIDTH(WIDTH)) u_ff_res (
    .clk(clk), .reset(reset), .d(d_alu_result), .q(ex_mem_alu_result)
  );
  d_ff #(.WIDTH(WIDTH)) u_ff_wdata (
    .clk(clk), .reset(reset), .d(d_wr_data), .q(ex_mem_wr_data)
  );
  d_ff #(.WIDTH(1)) u_ff_valid (
    .clk(clk), .reset(reset), .d(live), .q(ex_mem_valid)
  );

endmodule

// File: tb/tb_instr_execute.sv
// Self-checking bench for instr_execute: vector table with scoreboard, plus 2-slot squash sequences.
module tb_instr_execute;
  import mips_pkg::*;

  typedef struct {
    logic        jump, branch, m2r, mwe, src, rwe;
    logic [2:0]  ctrl;
    logic [4:0]  addr;
    logic [31:0] rd1, rd2, imm, pcb, pcj;
    logic        exp_redir;
    logic [31:0] exp_tgt;
    logic        exp_valid;
    logic [31:0] exp_res;
  } vec_t;

  typedef logic [72:0] exp_t;  // {valid, m2r, mwe, rwe, addr, result, wr_data}

  logic        clk = 1'b0;
  logic        reset1, reset2;
  logic        jump, branch, m2r, mwe, src, rwe;
  logic [2:0]  ctrl;
  logic [4:0]  addr;
  logic [31:0] rd1, rd2, imm, pcb, pcj;

  logic        r1_redir, r1_flush, r1_m2r, r1_mwe, r1_rwe, r1_valid;
  logic [31:0] r1_tgt, r1_res, r1_wdata;
  logic [4:0]  r1_addr;
  logic        r2_redir, r2_flush, r2_m2r, r2_mwe, r2_rwe, r2_valid;
  logic [31:0] r2_tgt, r2_res, r2_wdata;
  logic [4:0]  r2_addr;

  logic        sel2;
  logic        o_redir, o_flush;
  logic [31:0] o_tgt;
  exp_t        o_exmem;

  int tests = 0;
  int fails = 0;
  exp_t sb[$];
  vec_t vecs[19];

  always #5 clk = ~clk;

  instr_execute #(.WIDTH(32), .SQUASH_SLOTS(1)) dut1 (
    .clk(clk), .reset(reset1),
    .id_ex_jump(jump), .id_ex_branch(branch), .id_ex_mem_to_reg_wr(m2r),
    .id_ex_mem_wr_en(mwe), .id_ex_alu_src_sel(src), .id_ex_reg_wr_en(rwe),
    .id_ex_alu_ctrl(ctrl), .id_ex_reg_wr_addr(addr), .id_ex_reg_rd_data1(rd1),
    .id_ex_reg_rd_data2(rd2), .id_ex_sign_imm_ext(imm), .id_ex_pc_branch(pcb),
    .id_ex_pc_jump(pcj),
    .pc_redirect(r1_redir), .pc_target(r1_tgt), .flush_if_id(r1_flush),
    .ex_mem_mem_to_reg_wr(r1_m2r), .ex_mem_mem_wr_en(r1_mwe), .ex_mem_reg_wr_en(r1_rwe),
    .ex_mem_reg_wr_addr(r1_addr), .ex_mem_alu_result(r1_res), .ex_mem_wr_data(r1_wdata),
    .ex_mem_valid(r1_valid)
  );

  instr_execute #(.WIDTH(32), .SQUASH_SLOTS(2)) dut2 (
    .clk(clk), .reset(reset2),
    .id_ex_jump(jump), .id_ex_branch(branch), .id_ex_mem_to_reg_wr(m2r),
    .id_ex_mem_wr_en(mwe), .id_ex_alu_src_sel(src), .id_ex_reg_wr_en(rwe),
    .id_ex_alu_ctrl(ctrl), .id_ex_reg_wr_addr(addr), .id_ex_reg_rd_data1(rd1),
    .id_ex_reg_rd_data2(rd2), .id_ex_sign_imm_ext(imm), .id_ex_pc_branch(pcb),
    .id_ex_pc_jump(pcj),
    .pc_redirect(r2_redir), .pc_target(r2_tgt), .flush_if_id(r2_flush),
    .ex_mem_mem_to_reg_wr(r2_m2r), .ex_mem_mem_wr_en(r2_mwe), .ex_mem_reg_wr_en(r2_rwe),
    .ex_mem_reg_wr_addr(r2_addr), .ex_mem_alu_result(r2_res), .ex_mem_wr_data(r2_wdata),
    .ex_mem_valid(r2_valid)
  );

  always_comb begin
    o_redir = sel2 ? r2_redir : r1_redir;
    o_flush = sel2 ? r2_flush : r1_flush;
    o_tgt   = sel2 ? r2_tgt   : r1_tgt;
    o_exmem = sel2 ? {r2_valid, r2_m2r, r2_mwe, r2_rwe, r2_addr, r2_res, r2_wdata}
                   : {r1_valid, r1_m2r, r1_mwe, r1_rwe, r1_addr, r1_res, r1_wdata};
  end

  function automatic vec_t mk(input logic j, input logic b, input logic m2, input logic mw,
                              input logic s, input logic rw, input logic [2:0] c,
                              input logic [4:0] a, input logic [31:0] d1, input logic [31:0] d2,
                              input logic [31:0] im, input logic [31:0] pb, input logic [31:0] pj,
                              input logic er, input logic [31:0] et, input logic ev,
                              input logic [31:0] eres);
    vec_t v;
    v.jump = j; v.branch = b; v.m2r = m2; v.mwe = mw; v.src = s; v.rwe = rw;
    v.ctrl = c; v.addr = a; v.rd1 = d1; v.rd2 = d2; v.imm = im; v.pcb = pb; v.pcj = pj;
    v.exp_redir = er; v.exp_tgt = et; v.exp_valid = ev; v.exp_res = eres;
    return v;
  endfunction

  task automatic check(input string name, input logic [72:0] act, input logic [72:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    jump = v.jump; branch = v.branch; m2r = v.m2r; mwe = v.mwe; src = v.src; rwe = v.rwe;
    ctrl = v.ctrl; addr = v.addr; rd1 = v.rd1; rd2 = v.rd2; imm = v.imm;
    pcb = v.pcb; pcj = v.pcj;
  endtask

  // Drive one ID/EX slot, check the same-cycle redirect, then the EX/MEM result a cycle later.
  task automatic apply(input string name, input vec_t v);
    exp_t e;
    exp_t got;
    drive(v);
    e = v.exp_valid ? {1'b1, v.m2r, v.mwe, v.rwe, v.addr, v.exp_res, v.rd2} : '0;
    sb.push_back(e);
    #1;
    check({name, ".redirect"}, 73'(o_redir), 73'(v.exp_redir));
    check({name, ".flush"}, 73'(o_flush), 73'(v.exp_redir));
    if (v.exp_redir) check({name, ".target"}, 73'(o_tgt), 73'(v.exp_tgt));
    @(posedge clk);
    #1;
    got = o_exmem;
    if (sb.size() == 0) check({name, ".sb_empty"}, 73'(1), 73'(0));
    else check({name, ".exmem"}, got, sb.pop_front());
  endtask

  initial begin
    vecs[0]  = mk(0,0,0,0,0,1, ALU_ADD,  3, 32'd5, 32'd7, 0, 0, 0, 0, 0, 1, 32'd12);
    vecs[1]  = mk(0,0,0,0,0,1, ALU_SUB,  4, 32'd5, 32'd7, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFE);
    vecs[2]  = mk(0,0,0,0,0,1, ALU_SLT,  5, 32'hFFFF_FFFF, 32'd1, 0, 0, 0, 0, 0, 1, 32'd1);
    vecs[3]  = mk(0,0,0,0,1,1, ALU_ADD,  6, 32'd8, 32'h55, 32'hFFFF_FFFC, 0, 0, 0, 0, 1, 32'd4);
    vecs[4]  = mk(0,0,0,0,0,1, ALU_AND,  7, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0, 0, 0, 0, 0, 1, 32'h00F0_00F0);
    vecs[5]  = mk(0,0,0,0,0,1, ALU_OR,   8, 32'h1234_0000, 32'h0000_5678, 0, 0, 0, 0, 0, 1, 32'h1234_5678);
    vecs[6]  = mk(0,0,0,0,0,1, 3'b011,   9, 32'd5, 32'd7, 0, 0, 0, 0, 0, 1, 32'd0);
    vecs[7]  = mk(0,0,0,0,0,1, ALU_SLT, 10, 32'd1, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 1, 32'd0);
    vecs[8]  = mk(0,1,0,0,0,0, ALU_SUB,  0, 32'd9, 32'd9, 0, 32'h40, 32'h999, 1, 32'h40, 1, 32'd0);
    vecs[9]  = mk(0,0,0,0,0,1, ALU_ADD, 11, 32'd1, 32'd1, 0, 0, 0, 0, 0, 0, 32'd0);
    vecs[10] = mk(0,0,0,0,0,1, ALU_ADD, 12, 32'd2, 32'd3, 0, 0, 0, 0, 0, 1, 32'd5);
    vecs[11] = mk(0,1,0,0,0,0, ALU_SUB,  0, 32'd1, 32'd2, 0, 32'h80, 0, 0, 0, 1, 32'hFFFF_FFFF);
    vecs[12] = mk(0,0,0,0,0,1, ALU_ADD, 13, 32'd4, 32'd4, 0, 0, 0, 0, 0, 1, 32'd8);
    vecs[13] = mk(1,1,0,0,0,0, ALU_SUB,  0, 32'd3, 32'd3, 0, 32'h40, 32'h100, 1, 32'h100, 1, 32'd0);
    vecs[14] = mk(1,0,0,0,0,0, ALU_ADD,  0, 32'd1, 32'd2, 0, 0, 32'h200, 0, 0, 0, 32'd0);
    vecs[15] = mk(0,0,0,0,0,1, ALU_ADD, 14, 32'h7FFF_FFFF, 32'd1, 0, 0, 0, 0, 0, 1, 32'h8000_0000);
    vecs[16] = mk(0,0,0,1,1,0, ALU_ADD,  0, 32'h100, 32'hDEAD_BEEF, 32'd8, 0, 0, 0, 0, 1, 32'h108);
    vecs[17] = mk(0,0,1,0,1,1, ALU_ADD, 15, 32'h100, 32'd0, 32'd4, 0, 0, 0, 0, 1, 32'h104);
    vecs[18] = mk(0,0,0,0,0,1, ALU_ADD, 16, 32'hFFFF_FFFF, 32'd1, 0, 0, 0, 0, 0, 1, 32'd0);

    // Reset with a live-looking jump and write on the inputs
    sel2 = 1'b0;
    reset1 = 1'b1; reset2 = 1'b1;
    drive(mk(1,1,1,1,0,1, ALU_ADD, 31, 32'd9, 32'd9, 32'd1, 32'h40, 32'h80, 0, 0, 0, 0));
    #1;
    check("reset.redirect1", 73'(r1_redir), 73'(0));
    check("reset.redirect2", 73'(r2_redir), 73'(0));
    @(posedge clk);
    #1;
    check("reset.exmem1", {r1_valid, r1_m2r, r1_mwe, r1_rwe, r1_addr, r1_res, r1_wdata}, '0);
    check("reset.exmem2", {r2_valid, r2_m2r, r2_mwe, r2_rwe, r2_addr, r2_res, r2_wdata}, '0);

    reset1 = 1'b0;
    for (int i = 0; i < 19; i++) apply($sformatf("vec%0d", i), vecs[i]);

    // Two squash slots: jump, two bubbles (second one a beq that would be taken), then live
    reset1 = 1'b1; reset2 = 1'b0; sel2 = 1'b1;
    apply("s2.jump",   mk(1,0,0,0,0,0, ALU_ADD, 0, 32'd1, 32'd2, 0, 0, 32'h200, 1, 32'h200, 1, 32'd3));
    apply("s2.bub1",   mk(0,0,0,0,0,1, ALU_ADD, 5, 32'd1, 32'd1, 0, 0, 0, 0, 0, 0, 0));
    apply("s2.bub2",   mk(0,1,0,0,0,0, ALU_SUB, 0, 32'd7, 32'd7, 0, 32'h44, 0, 0, 0, 0, 0));
    apply("s2.live",   mk(0,0,0,0,0,1, ALU_ADD, 6, 32'd10, 32'd20, 0, 0, 0, 0, 0, 1, 32'd30));

    // Reset during the first bubble clears the pending squash
    apply("s2r.jump",  mk(1,0,0,0,0,0, ALU_ADD, 0, 32'd1, 32'd1, 0, 0, 32'h300, 1, 32'h300, 1, 32'd2));
    reset2 = 1'b1;
    apply("s2r.reset", mk(0,0,0,0,0,1, ALU_ADD, 7, 32'd3, 32'd3, 0, 0, 0, 0, 0, 0, 0));
    reset2 = 1'b0;
    apply("s2r.live",  mk(0,0,0,0,0,1, ALU_ADD, 8, 32'd4, 32'd5, 0, 0, 0, 0, 0, 1, 32'd9));

    // Reset coincident with a jump: no redirect and no squash counted
    reset2 = 1'b1;
    apply("s2c.reset", mk(1,0,0,0,0,0, ALU_ADD, 0, 32'd1, 32'd1, 0, 0, 32'h400, 0, 0, 0, 0));
    reset2 = 1'b0;
    apply("s2c.live",  mk(0,0,0,0,0,1, ALU_SUB, 9, 32'd100, 32'd1, 0, 0, 0, 0, 0, 1, 32'd99));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
